// File: rtl/if_fetch_ctrl.sv
// IF-stage fetch controller: owns the PC, reads instruction memory and buffers up to two fetched {pc, inst} entries for ID.
// Optional macro IF_FETCH_CTRL_ALIGN_CHK_EN turns a misaligned redirect into a sticky fetch fault.
module if_fetch_ctrl #(
  parameter int              WORD      = 32,
  parameter int              INST_SIZE = 32,
  parameter logic [WORD-1:0] RESET_PC  = {WORD{1'b0}}
) (
  input  logic                 clk,
  input  logic                 rst,
  output logic                 mem_read,
  output logic [WORD-1:0]      mem_pc,
  input  logic [INST_SIZE-1:0] mem_inst,
  input  logic                 redirect,
  input  logic [WORD-1:0]      redirect_pc,
  output logic                 if_valid,
  input  logic                 if_ready,
  output logic [INST_SIZE-1:0] if_inst,
  output logic [WORD-1:0]      if_pc,
  output logic                 fetch_fault
);

`ifdef IF_FETCH_CTRL_ALIGN_CHK_EN
  typedef enum logic [1:0] {S_IDLE = 2'd0, S_RUN = 2'd1, S_FAULT = 2'd2} state_e;
`else
  typedef enum logic [1:0] {S_IDLE = 2'd0, S_RUN = 2'd1} state_e;
`endif

  localparam logic [WORD-1:0] ALIGN_MASK = {{(WORD-2){1'b1}}, 2'b00};
  localparam logic [WORD-1:0] PC_STEP    = {{(WORD-3){1'b0}}, 3'b100};

  state_e                 state_q, state_d;
  logic [WORD-1:0]        pc_q, pc_d;
  logic [1:0]             count_q, count_d;
  logic                   head_q, head_d;
  logic                   tail_q, tail_d;
  logic [WORD-1:0]        ent_pc_q   [2];
  logic [INST_SIZE-1:0]   ent_inst_q [2];
  logic                   push_s;
  logic                   pop_s;

`ifdef IF_FETCH_CTRL_ALIGN_CHK_EN
  logic misalign_s;
  assign misalign_s = (redirect_pc[1:0] != 2'b00);
`endif

  // Next-state logic: FSM, PC, buffer occupancy and pointers
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    count_d = count_q;
    head_d  = head_q;
    tail_d  = tail_q;
    push_s  = 1'b0;
    pop_s   = 1'b0;
    case (state_q)
      S_IDLE: begin
        state_d = S_RUN;
        if (redirect) begin
`ifdef IF_FETCH_CTRL_ALIGN_CHK_EN
          if (misalign_s) begin
            state_d = S_FAULT;
          end else begin
            pc_d = redirect_pc & ALIGN_MASK;
          end
`else
          pc_d = redirect_pc & ALIGN_MASK;
`endif
        end else begin
          pc_d = pc_q;
        end
      end
      S_RUN: begin
        if (redirect) begin
          // Flush wins over any push or pop in the same cycle
          count_d = 2'd0;
          head_d  = 1'b0;
          tail_d  = 1'b0;
`ifdef IF_FETCH_CTRL_ALIGN_CHK_EN
          if (misalign_s) begin
            state_d = S_FAULT;
          end else begin
            pc_d = redirect_pc & ALIGN_MASK;
          end
`else
          pc_d = redirect_pc & ALIGN_MASK;
`endif
        end else begin
          push_s = (count_q != 2'd2);
          pop_s  = (count_q != 2'd0) && if_ready;
          if (push_s) begin
            tail_d = ~tail_q;
            pc_d   = pc_q + PC_STEP;
          end else begin
            tail_d = tail_q;
          end
          if (pop_s) begin
            head_d = ~head_q;
          end else begin
            head_d = head_q;
          end
          count_d = count_q + {1'b0, push_s} - {1'b0, pop_s};
        end
      end
`ifdef IF_FETCH_CTRL_ALIGN_CHK_EN
      S_FAULT: begin
        state_d = S_FAULT;
      end
`endif
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State, PC and buffer registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= S_IDLE;
      pc_q          <= RESET_PC;
      count_q       <= 2'd0;
      head_q        <= 1'b0;
      tail_q        <= 1'b0;
      ent_pc_q[0]   <= {WORD{1'b0}};
      ent_pc_q[1]   <= {WORD{1'b0}};
      ent_inst_q[0] <= {INST_SIZE{1'b0}};
      ent_inst_q[1] <= {INST_SIZE{1'b0}};
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      count_q <= count_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      if (push_s) begin
        ent_pc_q[tail_q]   <= pc_q;
        ent_inst_q[tail_q] <= mem_inst;
      end
    end
  end

  // Fetch does not look at if_ready, so ID has no combinational path to memory
  assign mem_read = push_s;
  assign mem_pc   = pc_q;
  assign if_valid = (count_q != 2'd0);
  assign if_inst  = if_valid ? ent_inst_q[head_q] : {INST_SIZE{1'b0}};
  assign if_pc    = if_valid ? ent_pc_q[head_q]   : {WORD{1'b0}};

`ifdef IF_FETCH_CTRL_ALIGN_CHK_EN
  assign fetch_fault = (state_q == S_FAULT);
`else
  assign fetch_fault = 1'b0;
`endif

endmodule

// File: doc/if_fetch_ctrl.md
# if_fetch_ctrl

Instruction-fetch controller for the IF stage. It owns the program counter and drives the instruction memory's `read` and `pc` inputs, then captures the returned instruction into a 2-entry buffer. The buffer presents fetched instructions to ID with a valid/ready handshake. It sits between the instruction memory and the IF/ID boundary, and absorbs decode back-pressure and branch redirects (flush).

## Interface
Parameters:
- `RESET_PC`, 0, byte address fetched first after reset; `WORD` bits wide, must be 4-byte aligned.

Ports (widths use `WORD` and `INST_SIZE` from `common.vh`):
- `clk`  input  1  single clock; all state updates on the rising edge.
- `rst`  input  1  reset; synchronous, active-high.
- `mem_read`  output  1  read enable to instruction memory.
- `mem_pc`  output  `WORD`  byte address to instruction memory.
- `mem_inst`  input  `INST_SIZE`  instruction from memory; combinational, valid in the same cycle as `mem_read`/`mem_pc`.
- `redirect`  input  1  branch/jump taken; flush and restart fetch.
- `redirect_pc`  input  `WORD`  target byte address for `redirect`.
- `if_valid`  output  1  buffer head holds a valid instruction.
- `if_ready`  input  1  ID accepts the head this cycle.
- `if_inst`  output  `INST_SIZE`  head instruction.
- `if_pc`  output  `WORD`  byte address of head instruction.
- `fetch_fault`  output  1  misaligned-redirect fault; sticky.

## Operation
- FSM states: IDLE, RUN, FAULT.
  - FAULT is reachable only with `IF_FETCH_CTRL_ALIGN_CHK_EN`.
  - Reset enters IDLE.
  - IDLE → RUN unconditionally on the next edge, leaving one bubble cycle.
- Registered state:
  - `pc_q`: next fetch address.
  - 2-entry FIFO of {pc, inst}.
  - `count`: 0..2.
  - head/tail pointers.
- Push condition (RUN only): `mem_read = (count < 2) && !redirect`; `mem_pc = pc_q` at all times.
  - Push does not depend on `if_ready`, so there is no combinational path from ID to memory.
- On push: the entry {`pc_q`, `mem_inst`} is written at the tail, and `pc_q <= pc_q + 4`.
  - The add is modulo 2^`WORD`, so `pc_q` wraps from all-ones−3 to 0.
- Pop: `if_valid && if_ready`; the head advances.
  - Push and pop in the same cycle leave `count` unchanged and sustain one instruction per cycle.
- Outputs: `if_valid = (count != 0)`; `if_inst`/`if_pc` come from the head entry.
  - When `if_valid` = 0, `if_inst`/`if_pc` are driven 0.
- Redirect (RUN, highest priority):
  - Clears `count` and pointers.
  - Loads `pc_q <= redirect_pc`.
  - Suppresses the push that cycle.
  - Any pop that cycle is discarded. ID must ignore the IF output in the redirect cycle.
- Redirect in IDLE: still loads `pc_q`; the FSM moves to RUN as normal.
- `rst` overrides everything, including in the middle of a redirect or a full buffer.

## Timing
- Reset values:
  - `mem_read` = 0.
  - `mem_pc` = `RESET_PC`.
  - `if_valid` = 0.
  - `if_inst` = 0.
  - `if_pc` = 0.
  - `fetch_fault` = 0.
  - `count` = 0.
- Sequence after `rst` deasserts:
  - Cycle 0: IDLE, `mem_read` = 0.
  - Cycle 1: first fetch at `RESET_PC`.
  - Cycle 2: `if_valid` = 1 with that instruction.
- Fetch-to-valid latency is one cycle.
- Redirect-to-valid latency:
  - Redirect asserted in cycle N.
  - Fetch of `redirect_pc` in cycle N+1.
  - `if_valid` in cycle N+2.
- Back-pressure: with `if_ready` = 0, the buffer fills in two fetch cycles, then `mem_read` = 0 and `pc_q` holds.
  - When a pop drops `count` to 1, fetch resumes on the next cycle.
- Boundaries:
  - Empty with no pop: `if_valid` = 0.
  - Full: no push.
  - Count 1 with push and pop: count stays 1.

## Configuration
- `IF_FETCH_CTRL_ALIGN_CHK_EN` defined:
  - A redirect with `redirect_pc[1:0] != 0` flushes the buffer and enters FAULT.
  - In FAULT: `fetch_fault` = 1, `mem_read` = 0, `if_valid` = 0, and all further redirects are ignored until `rst`.
- Not defined:
  - `redirect_pc[1:0]` is forced to 00 when loaded into `pc_q`.
  - `fetch_fault` is tied 0.
  - The FAULT state is absent.

## Test plan
- Reset then free run, `RESET_PC` = 0, `if_ready` = 1:
  - `if_valid` first rises 2 cycles after reset deasserts.
  - `if_pc` then runs 0, 4, 8, … one per cycle.
  - `if_inst` matches memory words 0, 1, 2.
- Back-pressure: `if_ready` = 0 for 5 cycles after the first valid.
  - `mem_read` drops after count reaches 2.
  - `pc_q` holds at 8.
  - After `if_ready` = 1, the pops are 0, 4, 8 with no skips or duplicates.
- Redirect to 0x40 while the buffer holds 2 entries:
  - Next cycle: `if_valid` = 0 and `mem_pc` = 0x40.
  - Cycle after: `if_pc` = 0x40.
- Simultaneous redirect and `if_ready` with count = 1: redirect wins, count = 0, and the next head is `redirect_pc`.
- Wrap: redirect to 2^`WORD`−4, then the following fetch address is 0.
- Misaligned redirect to 0x42:
  - With the macro: `fetch_fault` = 1 and stays 1; a later redirect to 0x80 is ignored; `rst` clears the fault.
  - Without the macro: the fetch is at 0x40.
